// File: rtl/jt8255_peri_pkg.sv
// Shared encodings and default parameters for the jt8255 handshake bridge.
package jt8255_peri_pkg;

  localparam int unsigned DefDepth  = 4;
  localparam int unsigned DefStbLen = 2;
  localparam int unsigned DefAckLen = 2;
  // Wide enough for STB_LEN/ACK_LEN up to 15.
  localparam int unsigned CntW      = 4;

  typedef enum logic [2:0] {
    TxIdle,
    TxSetup,
    TxStrobe,
    TxWaitHi,
    TxWaitLo
  } tx_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxSettle,
    RxAck,
    RxWaitHi
  } rx_state_e;

endpackage

// File: rtl/jt8255_peri_fifo.sv
// 8-bit synchronous show-ahead FIFO; head is presented combinationally while non-empty.
module jt8255_peri_fifo
  import jt8255_peri_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_wdata,
  input  logic       i_push,
  output logic       o_full,
  output logic [7:0] o_rdata,
  output logic       o_empty,
  input  logic       i_pop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/jt8255_peri.sv
// Bridge between byte streams and a jt8255 in mode 1: TX drives the strobed input port,
// RX drains the strobed output port. The two handshakes run independently.
module jt8255_peri
  import jt8255_peri_pkg::*;
#(
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned STB_LEN = DefStbLen,
  parameter int unsigned ACK_LEN = DefAckLen
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic [7:0] o_pio_dout,
  output logic       o_stb,
  input  logic       i_ibf,
  input  logic [7:0] i_pio_din,
  input  logic       i_obf,
  output logic       o_ack
);

  localparam logic [CntW-1:0] StbLast = CntW'(STB_LEN - 1);
  localparam logic [CntW-1:0] AckLast = CntW'(ACK_LEN - 1);

  tx_state_e       r_tx_state, w_tx_state_nxt;
  rx_state_e       r_rx_state, w_rx_state_nxt;
  logic [CntW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [CntW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [7:0]      r_pio_dout, w_pio_dout_nxt;
  logic            r_stb;
  logic            r_ack;
  logic            w_tx_full, w_tx_empty, w_tx_pop, w_tx_push;
  logic [7:0]      w_tx_head;
  logic            w_rx_full, w_rx_empty, w_rx_push;

  assign w_tx_push  = i_tx_valid && !w_tx_full;
  assign o_tx_ready = !w_tx_full;
  assign o_rx_valid = !w_rx_empty;
  assign o_pio_dout = r_pio_dout;
  assign o_stb      = r_stb;
  assign o_ack      = r_ack;

  jt8255_peri_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wdata (i_tx_data),
    .i_push  (w_tx_push),
    .o_full  (w_tx_full),
    .o_rdata (w_tx_head),
    .o_empty (w_tx_empty),
    .i_pop   (w_tx_pop)
  );

  jt8255_peri_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wdata (i_pio_din),
    .i_push  (w_rx_push),
    .o_full  (w_rx_full),
    .o_rdata (o_rx_data),
    .o_empty (w_rx_empty),
    .i_pop   (i_rx_ready)
  );

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_pio_dout_nxt = r_pio_dout;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TxIdle: begin
        if (!w_tx_empty && !i_ibf) begin
          w_tx_pop       = 1'b1;
          w_pio_dout_nxt = w_tx_head;
          w_tx_state_nxt = TxSetup;
        end
      end
      TxSetup: begin
        w_tx_cnt_nxt   = '0;
        w_tx_state_nxt = TxStrobe;
      end
      TxStrobe: begin
        if (r_tx_cnt == StbLast) w_tx_state_nxt = TxWaitHi;
        else                     w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
      end
      TxWaitHi: if (i_ibf)  w_tx_state_nxt = TxWaitLo;
      TxWaitLo: if (!i_ibf) w_tx_state_nxt = TxIdle;
      default:  w_tx_state_nxt = TxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TxIdle;
      r_tx_cnt   <= '0;
      r_pio_dout <= 8'hff;
      r_stb      <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_pio_dout <= w_pio_dout_nxt;
      r_stb      <= (w_tx_state_nxt == TxStrobe);
    end
  end

  // The 8255 port register lags the write by a cycle, so capture at the end of SETTLE.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_push      = 1'b0;
    case (r_rx_state)
      RxIdle:   if (!i_obf && !w_rx_full) w_rx_state_nxt = RxSettle;
      RxSettle: begin
        w_rx_push      = 1'b1;
        w_rx_cnt_nxt   = '0;
        w_rx_state_nxt = RxAck;
      end
      RxAck: begin
        if (r_rx_cnt == AckLast) w_rx_state_nxt = RxWaitHi;
        else                     w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
      end
      RxWaitHi: if (i_obf) w_rx_state_nxt = RxIdle;
      default:  w_rx_state_nxt = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RxIdle;
      r_rx_cnt   <= '0;
      r_ack      <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_ack      <= (w_rx_state_nxt == RxAck);
    end
  end

endmodule

// File: tb/tb_jt8255_peri.sv
// Bench for jt8255_peri: a behavioural mode-1 8255 (port A strobed input, port B strobed
// output) plus byte scoreboards checked every cycle, and directed handshake scenarios.
module tb_jt8255_peri;

  localparam int unsigned Depth  = 4;
  localparam int unsigned StbLen = 2;
  localparam int unsigned AckLen = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] pio_dout, pio_din;
  logic       stb, ibf, obf, ack;

  always #5 clk = ~clk;

  jt8255_peri #(.DEPTH(Depth), .STB_LEN(StbLen), .ACK_LEN(AckLen)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid),
    .o_tx_ready (tx_ready),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .i_rx_ready (rx_ready),
    .o_pio_dout (pio_dout),
    .o_stb      (stb),
    .i_ibf      (ibf),
    .i_pio_din  (pio_din),
    .i_obf      (obf),
    .o_ack      (ack)
  );

  // 8255 model: port A latches on stb rise, port B output register with active-low OBF.
  logic [7:0] a_latch, b_out, cpu_wr_data;
  logic       a_ibf, a_stale, stb_prev, b_obf_n, ack_prev;
  logic       cpu_rd_a, cpu_wr_b, inj_stale;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_latch <= 8'h00; a_ibf <= 1'b0; a_stale <= 1'b0; stb_prev <= 1'b0;
      b_out <= 8'h00; b_obf_n <= 1'b1; ack_prev <= 1'b0;
    end else begin
      stb_prev <= stb;
      ack_prev <= ack;
      if (cpu_rd_a) begin a_ibf <= 1'b0; a_stale <= 1'b0; end
      if (inj_stale) begin a_ibf <= 1'b1; a_stale <= 1'b1; a_latch <= 8'hEE; end
      if (stb && !stb_prev) begin a_ibf <= 1'b1; a_stale <= 1'b0; a_latch <= pio_dout; end
      if (cpu_wr_b) begin b_out <= cpu_wr_data; b_obf_n <= 1'b0; end
      if (ack && !ack_prev) b_obf_n <= 1'b1;
    end
  end

  assign ibf     = a_ibf;
  assign obf     = b_obf_n;
  assign pio_din = b_out;

  int n_chk = 0, n_fail = 0, cyc = 0, deadline = 0;
  int n_stb = 0, n_ack = 0, n_rd = 0, n_pop = 0;
  int stb_run = 0, ack_run = 0;
  logic       stb_q1 = 1'b0, ack_q1 = 1'b0;
  logic [7:0] stb_data;
  logic [7:0] tx_stb_q[$], tx_rd_q[$], rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Compare process: scoreboards and pulse rules, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      tx_stb_q.delete(); tx_rd_q.delete(); rx_q.delete();
      stb_run = 0; ack_run = 0; stb_q1 = 1'b0; ack_q1 = 1'b0;
      check("stb_in_reset", stb, 0);
      check("ack_in_reset", ack, 0);
    end else begin
      if (tx_valid && tx_ready) begin
        tx_stb_q.push_back(tx_data);
        tx_rd_q.push_back(tx_data);
      end
      if (stb && !stb_q1) begin
        n_stb++;
        stb_data = pio_dout;
        check("stb_ibf_clear", ibf, 0);
        check("stb_pending", tx_stb_q.size() != 0, 1);
        if (tx_stb_q.size() != 0) check("stb_data", pio_dout, tx_stb_q.pop_front());
      end
      if (stb) begin
        stb_run++;
        check("stb_hold", pio_dout, stb_data);
      end else if (stb_run != 0) begin
        check("stb_width", stb_run, StbLen);
        stb_run = 0;
      end
      stb_q1 = stb;
      if (ack && !ack_q1) begin
        n_ack++;
        check("ack_obf_low", obf, 0);
      end
      if (ack) ack_run++;
      else if (ack_run != 0) begin
        check("ack_width", ack_run, AckLen);
        ack_run = 0;
      end
      ack_q1 = ack;
      if (cpu_rd_a && ibf && !a_stale) begin
        check("rd_pending", tx_rd_q.size() != 0, 1);
        if (tx_rd_q.size() != 0) begin
          check("rd_data", a_latch, tx_rd_q.pop_front());
          n_rd++;
        end
      end
      if (cpu_wr_b) rx_q.push_back(cpu_wr_data);
      if (rx_valid) begin
        check("rx_pending", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          check("rx_head", rx_data, rx_q[0]);
          if (rx_ready) begin
            void'(rx_q.pop_front());
            n_pop++;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && cyc < deadline) tick;
    check("push_wait", tx_ready, 1);
    tick;
    tx_valid = 1'b0;
  endtask

  task automatic cpu_read_a;
    while (!(ibf && !stb) && cyc < deadline) tick;
    check("rd_wait", ibf && !stb, 1);
    cpu_rd_a = 1'b1;
    tick;
    cpu_rd_a = 1'b0;
  endtask

  task automatic cpu_write_b(input logic [7:0] b);
    while (!(obf && !ack) && cyc < deadline) tick;
    check("wr_wait", obf && !ack, 1);
    cpu_wr_data = b;
    cpu_wr_b    = 1'b1;
    tick;
    cpu_wr_b    = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  int base_stb, base_ack, base_rd, base_pop;

  initial begin
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    cpu_rd_a = 1'b0; cpu_wr_b = 1'b0; inj_stale = 1'b0; cpu_wr_data = 8'h00;
    tick; tick;
    check("rst_stb", stb, 0);
    check("rst_ack", ack, 0);
    check("rst_pio", pio_dout, 8'hff);
    check("rst_txrdy", tx_ready, 1);
    check("rst_rxvld", rx_valid, 0);
    check("rst_rxdata", rx_data, 8'h00);
    rst = 1'b0;
    tick; tick;
    check("idle_stb", stb, 0);

    // Single TX byte with exact handshake timing.
    deadline = cyc + 300;
    base_stb = n_stb;
    push(8'h5A);
    tick; check("tx_setup_data", pio_dout, 8'h5A); check("tx_setup_stb", stb, 0);
    tick; check("tx_strobe1", stb, 1);
    tick; check("tx_strobe2", stb, 1); check("tx_ibf_hi", ibf, 1);
    check("tx_latch", a_latch, 8'h5A);
    tick; check("tx_strobe_end", stb, 0);
    cpu_read_a;
    tick; check("tx_ibf_lo", ibf, 0);
    repeat (4) tick;
    check("tx_one_stb", n_stb - base_stb, 1);
    check("tx_dout_hold", pio_dout, 8'h5A);

    // Single RX byte.
    base_ack = n_ack;
    cpu_write_b(8'hC3);
    check("rx_obf_lo", obf, 0);
    tick; check("rx_settle_ack", ack, 0); check("rx_settle_vld", rx_valid, 0);
    tick; check("rx_ack1", ack, 1); check("rx_vld", rx_valid, 1);
    check("rx_data", rx_data, 8'hC3);
    tick; check("rx_ack2", ack, 1); check("rx_obf_hi", obf, 1);
    tick; check("rx_ack_end", ack, 0);
    rx_ready = 1'b1; tick; rx_ready = 1'b0;
    check("rx_popped", rx_valid, 0);
    check("rx_one_ack", n_ack - base_ack, 1);

    // Burst behind a stale port A byte: FIFO fills at 4, nothing strobes until it is read.
    deadline = cyc + 2000;
    base_stb = n_stb; base_rd = n_rd;
    inj_stale = 1'b1; tick; inj_stale = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("burst_full", tx_ready, 0);
    check("burst_no_stb", n_stb - base_stb, 0);
    fork
      push(8'h05);
      begin repeat (6) cpu_read_a; end
    join
    repeat (10) tick;
    check("burst_reads", n_rd - base_rd, 5);
    check("burst_stbs", n_stb - base_stb, 5);
    check("burst_drained", tx_rd_q.size(), 0);

    // RX back-pressure: 4 stored, 5th held in the 8255 without ack.
    deadline = cyc + 2000;
    base_ack = n_ack; base_pop = n_pop;
    for (int i = 0; i < 5; i++) cpu_write_b(8'h10 + 8'(i));
    repeat (30) tick;
    check("bp_acks", n_ack - base_ack, 4);
    check("bp_obf_pending", obf, 0);
    check("bp_no_ack", ack, 0);
    check("bp_valid", rx_valid, 1);
    check("bp_head", rx_data, 8'h10);
    rx_ready = 1'b1;
    while (n_pop - base_pop < 5 && cyc < deadline) tick;
    rx_ready = 1'b0;
    check("bp_pops", n_pop - base_pop, 5);
    check("bp_acks_all", n_ack - base_ack, 5);

    // Reset in the middle of a strobe with both FIFOs holding data.
    deadline = cyc + 500;
    cpu_write_b(8'h44);
    while (!rx_valid && cyc < deadline) tick;
    check("rst_rx_loaded", rx_valid, 1);
    push(8'h77); push(8'h78); push(8'h79);
    while (!stb && cyc < deadline) tick;
    check("rst_saw_stb", stb, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_stb", stb, 0);
    check("rst_mid_pio", pio_dout, 8'hff);
    check("rst_mid_txrdy", tx_ready, 1);
    check("rst_mid_rxvld", rx_valid, 0);
    check("rst_mid_rxdata", rx_data, 8'h00);
    repeat (3) tick;
    rst = 1'b0;
    base_stb = n_stb; base_ack = n_ack;
    repeat (20) tick;
    check("rst_no_stray_stb", n_stb - base_stb, 0);
    check("rst_no_stray_ack", n_ack - base_ack, 0);
    check("rst_ibf_clear", ibf, 0);
    check("rst_txrdy_after", tx_ready, 1);

    // Concurrent random traffic both ways.
    deadline = cyc + 50000;
    base_rd = n_rd; base_pop = n_pop; base_stb = n_stb;
    fork
      begin
        for (int i = 0; i < 1000 && cyc < deadline; i++) begin
          push(8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 2)) tick;
        end
      end
      begin
        while (n_rd - base_rd < 1000 && cyc < deadline) begin
          if (ibf && !stb && !a_stale && $urandom_range(0, 2) == 0) begin
            cpu_rd_a = 1'b1; tick; cpu_rd_a = 1'b0;
          end else tick;
        end
      end
      begin
        for (int i = 0; i < 1000 && cyc < deadline; i++) begin
          repeat ($urandom_range(0, 3)) tick;
          cpu_write_b(8'($urandom_range(0, 255)));
        end
      end
      begin
        while (n_pop - base_pop < 1000 && cyc < deadline) begin
          rx_ready = 1'($urandom_range(0, 1));
          tick;
        end
        rx_ready = 1'b0;
      end
    join
    repeat (5) tick;
    check("conc_reads", n_rd - base_rd, 1000);
    check("conc_stbs", n_stb - base_stb, 1000);
    check("conc_pops", n_pop - base_pop, 1000);
    check("conc_tx_left", tx_rd_q.size(), 0);
    check("conc_rx_left", rx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
